// File: rtl/inst_fetch.sv
// inst_fetch: RV32I instruction fetch stage.
// Owns the PC and keeps at most one request outstanding to instruction memory
// over req/gnt/rvalid. Each word is handed to decode with its PC through a
// valid/ready output register. Redirects squash in-flight or held fetches.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc
);

  localparam logic [31:0] PC_INIT = RESET_PC & 32'hFFFF_FFFC;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {REQ, WAIT, DROP, HOLD} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        if_valid_n;
  logic [31:0] if_inst_n, if_pc_n;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign imem_addr    = pc;
  // Reset forces state to REQ, so the request is also gated by rst.
  assign imem_req     = rst & (state == REQ);

  // State, PC and decode-facing output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= REQ;
      pc       <= PC_INIT;
      if_valid <= 1'b0;
      if_inst  <= NOP;
      if_pc    <= PC_INIT;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      if_valid <= if_valid_n;
      if_inst  <= if_inst_n;
      if_pc    <= if_pc_n;
    end
  end

  // Next-state, PC update and output capture.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    if_valid_n = if_valid;
    if_inst_n  = if_inst;
    if_pc_n    = if_pc;
    unique case (state)
      REQ: begin
        if (redirect) begin
          pc_n = redirect_tgt;
          // A grant in the redirect cycle was for the old address; its
          // response must still be absorbed before reissuing.
          if (imem_gnt) state_n = DROP;
        end else if (imem_gnt) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid && !redirect) begin
          if_inst_n  = imem_rdata;
          if_pc_n    = pc;
          if_valid_n = 1'b1;
          pc_n       = pc + 32'd4;
          state_n    = HOLD;
        end else if (imem_rvalid) begin
          pc_n    = redirect_tgt;
          state_n = REQ;
        end else if (redirect) begin
          pc_n    = redirect_tgt;
          state_n = DROP;
        end
      end
      DROP: begin
        if (redirect) pc_n = redirect_tgt;
        if (imem_rvalid) state_n = REQ;
      end
      HOLD: begin
        if (redirect) begin
          if_valid_n = 1'b0;
          pc_n       = redirect_tgt;
          state_n    = REQ;
        end else if (if_ready) begin
          if_valid_n = 1'b0;
          state_n    = REQ;
        end
      end
      default: state_n = REQ;
    endcase
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: directed scenarios followed by random traffic,
// all compared against a transaction-level model (outstanding/stale flags).
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model: pc, a granted request awaiting its word, whether that word is
  // to be thrown away, and the word currently offered to decode.
  logic [31:0] m_pc, m_inst, m_ipc;
  logic        m_busy, m_stale, m_valid;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_inst = NOP; m_ipc = RST_PC;
    m_busy = 1'b0; m_stale = 1'b0; m_valid = 1'b0;
  endtask

  task automatic compare_all();
    check("imem_req",  {31'd0, imem_req}, {31'd0, rst & !m_busy & !m_valid});
    check("imem_addr", imem_addr, m_pc);
    check("if_valid",  {31'd0, if_valid}, {31'd0, m_valid});
    if (m_valid) begin
      check("if_inst", if_inst, m_inst);
      check("if_pc",   if_pc,   m_ipc);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare at negedge.
  task automatic cycle(input logic g, input logic rv, input logic [31:0] rd,
                       input logic red, input logic [31:0] rpc, input logic rdy);
    logic req;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    redirect = red; redirect_pc = rpc; if_ready = rdy;
    @(posedge clk);
    req = !m_busy && !m_valid;
    if (req) begin
      if (g) begin m_busy = 1'b1; m_stale = red; end
    end else if (m_busy) begin
      if (rv) begin
        if (!m_stale && !red) begin
          m_valid = 1'b1; m_inst = rd; m_ipc = m_pc; m_pc = m_pc + 32'd4;
        end
        m_busy = 1'b0; m_stale = 1'b0;
      end else if (red) begin
        m_stale = 1'b1;
      end
    end else if (red || rdy) begin
      m_valid = 1'b0;
    end
    if (red) m_pc = {rpc[31:2], 2'b00};
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst = 1'b0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    redirect = 0; redirect_pc = '0; if_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_addr",  imem_addr, RST_PC);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_inst",  if_inst, NOP);
    check("rst_pc",    if_pc, RST_PC);
    rst = 1'b1;
    #1 check("first_req", {31'd0, imem_req}, 32'd1);

    // Basic fetch, then consume.
    cycle(1, 0, '0, 0, '0, 0);
    cycle(0, 1, 32'h0050_0093, 0, '0, 0);
    check("basic_valid", {31'd0, if_valid}, 32'd1);
    check("basic_inst",  if_inst, 32'h0050_0093);
    check("basic_pc",    if_pc, 32'h0);
    // Backpressure: five stalled cycles, then one transfer.
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 32'hAAAA_AAAA, 0, '0, 0);
      check("bp_req",  {31'd0, imem_req}, 32'd0);
      check("bp_inst", if_inst, 32'h0050_0093);
    end
    cycle(0, 0, '0, 0, '0, 1);
    check("bp_done", {31'd0, if_valid}, 32'd0);
    check("next_addr", imem_addr, 32'h4);

    // Redirect in WAIT, one cycle before rvalid.
    cycle(1, 0, '0, 0, '0, 0);
    cycle(0, 0, '0, 1, 32'h100, 0);
    cycle(0, 1, 32'hDEAD_BEEF, 0, '0, 0);
    check("rw_valid", {31'd0, if_valid}, 32'd0);
    check("rw_addr",  imem_addr, 32'h100);
    cycle(1, 0, '0, 0, '0, 0);
    cycle(0, 1, 32'h1111_1111, 0, '0, 0);
    check("rw_pc", if_pc, 32'h100);
    cycle(0, 0, '0, 0, '0, 1);

    // Redirect coinciding with gnt in REQ.
    cycle(1, 0, '0, 1, 32'h203, 0);
    check("rg_drop_req", {31'd0, imem_req}, 32'd0);
    cycle(0, 1, 32'h2222_2222, 0, '0, 0);
    check("rg_req",  {31'd0, imem_req}, 32'd1);
    check("rg_addr", imem_addr, 32'h200);

    // Wrap-around from the top word.
    cycle(0, 0, '0, 1, 32'hFFFF_FFFC, 0);
    cycle(1, 0, '0, 0, '0, 0);
    cycle(0, 1, 32'h3333_3333, 0, '0, 0);
    check("wrap_pc", if_pc, 32'hFFFF_FFFC);
    cycle(0, 0, '0, 0, '0, 1);
    check("wrap_addr", imem_addr, 32'h0);

    // Redirect in HOLD beats if_ready.
    cycle(1, 0, '0, 0, '0, 0);
    cycle(0, 1, 32'h4444_4444, 0, '0, 0);
    cycle(0, 0, '0, 1, 32'h40, 1);
    check("hr_valid", {31'd0, if_valid}, 32'd0);
    check("hr_addr",  imem_addr, 32'h40);

    // Async reset between gnt and rvalid.
    cycle(1, 0, '0, 0, '0, 0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("ar_req",   {31'd0, imem_req}, 32'd0);
    check("ar_addr",  imem_addr, RST_PC);
    check("ar_valid", {31'd0, if_valid}, 32'd0);
    check("ar_inst",  if_inst, NOP);
    @(negedge clk);
    rst = 1'b1;
    cycle(0, 1, 32'h5555_5555, 0, '0, 0);
    check("late_valid", {31'd0, if_valid}, 32'd0);
    check("late_req",   {31'd0, imem_req}, 32'd1);

    // Random traffic, including protocol-ignored inputs.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(1, 0) == 1, $urandom_range(9, 0) < 4, $urandom,
            $urandom_range(9, 0) == 0, $urandom, $urandom_range(1, 0) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the RV32I core, directly upstream of the decode/register-file stage. It owns the program counter and issues one word request at a time to instruction memory over a req/gnt/rvalid handshake. Each returned word is presented to decode together with its PC through a valid/ready output register. Branch and jump redirects from execute squash any in-flight or held fetch.

## Interface
- RESET_PC, default 32'h0000_0000: PC after reset. Bits [1:0] are treated as 0.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  word-aligned fetch address; always equals the pc register
- imem_gnt  in  1  memory accepted the request in this cycle
- imem_rvalid  in  1  imem_rdata is valid in this cycle; earliest is one cycle after gnt
- imem_rdata  in  32  returned instruction word
- redirect  in  1  branch/jump taken; load new PC
- redirect_pc  in  32  target PC; bits [1:0] are forced to 0
- if_valid  out  1  if_inst/if_pc hold a fetched instruction
- if_ready  in  1  decode accepts the instruction
- if_inst  out  32  instruction word to decode
- if_pc  out  32  address of if_inst

## Operation
- State register: REQ, WAIT, DROP, HOLD. The pc register is 32 bits.
- Increment rule: pc+4 is modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000.
- Redirect load: on every redirect the pc register loads {redirect_pc[31:2],2'b00}.
- imem_req: combinational, equals (state==REQ). There is never more than one outstanding request.
- REQ:
  - redirect with gnt: load pc, go to DROP. The old-address response is discarded.
  - redirect without gnt: load pc, stay in REQ. The request is reissued with the new address next cycle.
  - gnt without redirect: go to WAIT.
- WAIT:
  - rvalid without redirect: if_inst<=rdata, if_pc<=pc, if_valid<=1, pc<=pc+4, go to HOLD.
  - rvalid with redirect: discard rdata, load pc, go to REQ.
  - redirect without rvalid: load pc, go to DROP.
- DROP:
  - rvalid: discard it, go to REQ. A redirect in the same cycle also loads pc.
  - redirect without rvalid: load pc, stay in DROP.
- HOLD:
  - redirect: if_valid<=0, load pc, go to REQ. Redirect has priority even if if_ready=1 in the same cycle; that transfer counts as cancelled because decode is flushed by the same redirect.
  - if_ready without redirect: if_valid<=0, go to REQ.
  - neither: hold if_inst, if_pc and if_valid stable.
- Ignored inputs: imem_rvalid in REQ or HOLD, and imem_gnt outside REQ, have no effect.
- No decoding is performed here. The instruction word is passed through unmodified.

## Timing
- Reset (rst=0, async):
  - state=REQ, pc=RESET_PC.
  - if_valid=0, if_inst=32'h0000_0013 (NOP), if_pc=RESET_PC.
  - imem_req=0 while rst=0; imem_addr=RESET_PC.
- After reset release: imem_req=1 in the first cycle with rst=1.
- Fetch latency: with gnt in cycle N and rvalid in cycle N+1, if_valid=1 from cycle N+2.
- Throughput: best case 3 cycles per instruction (REQ, WAIT, HOLD). The next imem_req is asserted in the cycle after the if_ready handshake.
- Registered outputs: if_valid, if_inst and if_pc change only on clock edges or on reset.
- Reset mid-operation: any outstanding request is abandoned. A late rvalid after reset arrives in REQ and is ignored. The instruction memory is reset by the same rst.

## Test plan
- Basic fetch: RESET_PC=0, release rst, gnt in cycle 1, rvalid with 0x00500093 in cycle 2 → if_valid=1, if_inst=0x00500093, if_pc=0 in cycle 3. With if_ready=1, the next imem_addr is 0x4.
- Backpressure: hold if_ready=0 for 5 cycles in HOLD → if_valid, if_inst and if_pc stay stable and imem_req=0 throughout. Raising if_ready gives exactly one transfer.
- Redirect in WAIT: redirect_pc=0x100 one cycle before rvalid=0xDEADBEEF → 0xDEADBEEF never appears on if_inst, the next imem_addr is 0x100, and the following fetch reports if_pc=0x100.
- Redirect with gnt in REQ: redirect_pc=0x203 in the gnt cycle → DROP; one discarded rvalid, then imem_req with imem_addr=0x200.
- Wrap and HOLD redirect:
  - Redirect to 0xFFFF_FFFC, then fetch and consume → next imem_addr=0x0000_0000.
  - A redirect in HOLD with if_ready=1 clears if_valid without advancing to pc+4.
- Async reset mid-WAIT: pull rst low between gnt and rvalid → all outputs take reset values immediately, and a late rvalid after release is ignored.
